// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with 16x oversampling feeding a first-word-fall-through FIFO.
// Sticky framing-error and overrun flags are exported for the CPU status register.
module uart_rx_fifo #(
    parameter int BAUD_DIV = 26,
    parameter int FIFO_AW  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               RX,
    input  logic               rd,
    input  logic               clr_err,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    output logic               rx_full,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               frame_err,
    output logic               overrun
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic [1:0]         r_sync;
    logic [BW-1:0]      r_baud;
    state_t             r_state;
    logic [3:0]         r_tcnt;
    logic [2:0]         r_bcnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_frame_err;
    logic               r_overrun;

    logic w_rx_s;
    logic w_tick;
    logic w_stop_smp;
    logic w_push;
    logic w_ferr;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_wr;
    logic w_ovr;

    // Preset to idle-high so leaving reset cannot look like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RX};
        end
    end

    assign w_rx_s = r_sync[1];
    assign w_tick = (r_baud == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset || w_tick) begin
            r_baud <= '0;
        end else begin
            r_baud <= r_baud + 1'b1;
        end
    end

    assign w_stop_smp = w_tick && (r_state == S_STOP) && (r_tcnt == 4'd15);
    assign w_push     = w_stop_smp && w_rx_s;
    assign w_ferr     = w_stop_smp && !w_rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_tick && !w_rx_s) begin
                        r_state <= S_START;
                        r_tcnt  <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tcnt == 4'd7) begin
                            if (w_rx_s) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_DATA;
                                r_tcnt  <= '0;
                                r_bcnt  <= '0;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_tcnt == 4'd15) begin
                            r_shift <= {w_rx_s, r_shift[7:1]};
                            r_bcnt  <= r_bcnt + 1'b1;
                            r_tcnt  <= '0;
                            if (r_bcnt == 3'd7) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_tcnt == 4'd15) begin
                            r_tcnt  <= '0;
                            r_state <= w_rx_s ? S_IDLE : S_WAIT_HIGH;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    assign w_pop   = rd && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_ovr   = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_ferr) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_ovr) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data    = w_empty ? 8'h00 : r_mem[r_rptr];
    assign rx_valid   = !w_empty;
    assign rx_full    = w_full;
    assign fifo_count = r_count;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo against a queue-based model of the receive FIFO.
// Frames are driven bit by bit; state is compared in idle gaps between frames.
module tb_uart_rx_fifo;

    localparam int BD  = 4;
    localparam int AW  = 3;
    localparam int BIT = 16 * BD;
    localparam int DEP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          RX = 1'b1;
    logic          rd = 1'b0;
    logic          clr_err = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_full;
    logic [AW:0]   fifo_count;
    logic          frame_err;
    logic          overrun;

    int n_chk = 0;
    int n_err = 0;

    byte unsigned q[$];
    bit           m_fe = 1'b0;
    bit           m_ov = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .BAUD_DIV (BD),
        .FIFO_AW  (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .RX         (RX),
        .rd         (rd),
        .clr_err    (clr_err),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_full    (rx_full),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".cnt"}, 32'(fifo_count), 32'(q.size()));
        chk({tag, ".vld"}, 32'(rx_valid), 32'(q.size() > 0));
        chk({tag, ".full"}, 32'(rx_full), 32'(q.size() == DEP));
        chk({tag, ".fe"}, 32'(frame_err), 32'(m_fe));
        chk({tag, ".ov"}, 32'(overrun), 32'(m_ov));
        if (q.size() > 0) begin
            chk({tag, ".data"}, 32'(rx_data), 32'(q[0]));
        end
    endtask

    task automatic send(input logic [7:0] b, input int stop_low);
        RX = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            cyc(BIT);
        end
        if (stop_low > 0) begin
            RX = 1'b0;
            cyc(stop_low * BIT);
        end
        RX = 1'b1;
        cyc(BIT);
        if (stop_low > 0) begin
            m_fe = 1'b1;
        end else if (q.size() == DEP) begin
            m_ov = 1'b1;
        end else begin
            q.push_back(b);
        end
    endtask

    task automatic pop();
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
        if (q.size() > 0) begin
            void'(q.pop_front());
        end
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        reset = 1'b0;
        cyc(2);
        check_state("rst");
        chk("rst.data", 32'(rx_data), 32'h0);

        send(8'h55, 0);
        check_state("b55");
        pop();
        check_state("b55rd");
        pop();
        check_state("rdempty");

        RX = 1'b0;
        cyc(20);
        RX = 1'b1;
        cyc(200);
        check_state("glitch");

        send(8'hA3, 2);
        check_state("ferr");
        clear_errs();
        check_state("clr");
        send(8'h3C, 0);
        check_state("b3c");
        pop();

        for (int i = 0; i <= DEP; i++) begin
            send(8'(i), 0);
            if (i == DEP - 1) check_state("fill");
        end
        check_state("ovr");
        for (int i = 0; i < DEP; i++) begin
            check_state("drain");
            pop();
        end
        check_state("drained");
        clear_errs();

        for (int i = 0; i < DEP; i++) begin
            send(8'($urandom_range(0, 255)), 0);
        end
        check_state("refill");
        fork
            send(8'h99, 0);
            begin
                bit seen = 1'b0;
                for (int k = 0; k < 2000 && !seen; k++) begin
                    @(negedge clk);
                    if (dut.w_push) begin
                        rd = 1'b1;
                        @(negedge clk);
                        rd = 1'b0;
                        void'(q.pop_front());
                        seen = 1'b1;
                    end
                end
                chk("pushwait", 32'(seen), 32'h1);
            end
        join
        check_state("pushrd");
        while (q.size() > 0) begin
            check_state("drain2");
            pop();
        end
        check_state("drained2");

        send(8'h11, 0);
        send(8'h22, 1);
        send(8'h33, 0);
        check_state("prerst");
        RX = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 4; i++) begin
            RX = (i == 0);
            cyc(BIT);
        end
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        RX = 1'b1;
        q.delete();
        m_fe = 1'b0;
        m_ov = 1'b0;
        check_state("midrst");
        chk("midrst.data", 32'(rx_data), 32'h0);
        cyc(200);
        send(8'h7E, 0);
        check_state("b7e");
        pop();

        for (int it = 0; it < 40; it++) begin
            int r = $urandom_range(0, 9);
            if (r == 0) begin
                RX = 1'b0;
                cyc($urandom_range(1, 20));
                RX = 1'b1;
                cyc(100);
            end else begin
                send(8'($urandom_range(0, 255)), (r == 1) ? 1 : 0);
            end
            check_state("rnd");
            repeat ($urandom_range(0, 3)) pop();
            if ($urandom_range(0, 5) == 0) begin
                clear_errs();
            end
            cyc($urandom_range(0, 40));
            check_state("rndgap");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
